fifo_drain: RTL
===============

# fifo_drain

FIFO read-side engine for the PUCCH datapath. It pops words from the team's `fifo` block (`i_pop` / `o_data` / `o_valid` / `o_empty` interface) and re-presents them as a valid/ready stream with frame markers for the downstream symbol mapper. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so the stream runs at full throughput under backpressure.

## Interface
- `DATA_WIDTH`, 8, word width; must match the upstream `fifo`.
- `FRAME_LEN`, 12, words per frame (one PRB of subcarriers); ≥1. The beat counter is $clog2(FRAME_LEN) bits wide, minimum 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  permits new pops; words already fetched always drain.
- `i_fifo_data`  in  DATA_WIDTH  FIFO read data.
- `i_fifo_valid`  in  1  FIFO read-data valid, one cycle after a pop.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_pop`  out  1  pop request to FIFO; combinational.
- `o_data`  out  DATA_WIDTH  stream data (head of the skid buffer).
- `o_valid`  out  1  stream valid.
- `i_ready`  in  1  downstream ready.
- `o_last`  out  1  marks the final word of a frame; qualified by `o_valid`.
- `o_busy`  out  1  at least one word is buffered or in flight.
- `o_err`  out  1  sticky; `i_fifo_valid` arrived with no pop outstanding.

## Operation
- Upstream contract: a pop asserted in cycle N returns data with `i_fifo_valid` in cycle N+1. `i_fifo_empty` reflects FIFO state after the previous edge.
- State:
  - 2-entry buffer with head pointer and count `buf_cnt` (0..2).
  - In-flight flag `inflight`, registered from `o_fifo_pop`.
  - Beat counter `beat`.
  - Sticky `o_err`.
- Definitions:
  - `occ = buf_cnt + inflight`.
  - `fire = o_valid && i_ready`.
- Pop rule: `o_fifo_pop = i_en && !i_fifo_empty && (occ < 2 || (occ == 2 && fire))`. It is forced to 0 while `rst` is high.
- `i_fifo_valid` writes `i_fifo_data` at the buffer tail.
- `fire` retires the head.
- A simultaneous write and retire leaves `buf_cnt` unchanged, and the written word goes behind the remaining entries. Order is strictly FIFO.
- `o_valid = (buf_cnt != 0)`; `o_data` is the head entry.
- `o_busy = (occ != 0)`.
- Beat counter:
  - Increments on each `fire`.
  - Wraps to 0 after the fire with `beat == FRAME_LEN-1`.
  - Holds when there is no fire, including while `i_en` is low.
- `o_last = o_valid && (beat == FRAME_LEN-1)`. When FRAME_LEN=1, every word is last.
- Error: `i_fifo_valid && !inflight` sets `o_err`.
  - The word is still written if `buf_cnt < 2`; otherwise it is dropped.
  - `o_err` clears only on reset.
- Deasserting `i_en` mid-frame does not reset `beat`. The frame resumes where it stopped.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Outputs: `o_valid`=0, `o_data`=0, `o_last`=0, `o_busy`=0, `o_err`=0, `o_fifo_pop`=0.
  - Internal state: `buf_cnt`=0, `inflight`=0, `beat`=0.
  - Buffer contents clear to 0.
- Reset mid-operation discards buffered and in-flight words. An `i_fifo_valid` in the first cycle after reset release is an error.
- Latency: pop in cycle N → `i_fifo_valid` in N+1 → `o_valid` in N+2 (registered).
- Throughput: one word per cycle sustained while the FIFO is non-empty, `i_en`=1 and `i_ready`=1.
- Backpressure:
  - At most 2 words are held (`occ ≤ 2`), so no word is ever lost while `i_ready`=0.
  - `o_data` and `o_last` are stable while `o_valid && !i_ready`.
  - The first pop resumes in the same cycle that `i_ready` rises with `occ`=2.
- Empty: no pop is issued while `i_fifo_empty`=1, regardless of credit.

## Test plan
- **Frame at full throughput.** Reset 3 cycles, push 12 words 0x01..0x0C, hold `i_en`=1 and `i_ready`=1.
  - `o_fifo_pop` is high on 12 consecutive cycles.
  - `o_valid` is high on 12 consecutive cycles, starting 2 cycles after the first pop.
  - Data is 0x01..0x0C in order; `o_last` is high only with 0x0C.
- **Backpressure.** Push 8 words and hold `i_ready`=0 for 6 cycles.
  - Exactly 2 pops are issued; `o_data`=first word stays stable; `o_busy`=1.
  - On release, all 8 words come out in order with no gaps beyond the refill.
- **Sparse FIFO.** Push 1 word, wait 5 cycles, push 1 word.
  - Exactly 2 pops, 2 outputs, `beat` = 2.
  - No pop is issued while `i_fifo_empty`=1.
- **Enable pause.** Drop `i_en` after 5 words of a 12-word frame for 4 cycles.
  - Pops stop; up to 2 fetched words drain; `beat` holds.
  - After re-enable, `o_last` falls on the 12th word overall.
- **Spurious read data.** Force `i_fifo_valid`=1 with no prior pop.
  - `o_err` rises next cycle and stays 1 until reset.
- **Reset mid-operation.** Assert `rst` with 2 words buffered.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release and 12 fresh pushes, the next frame starts with `beat`=0.

Source files
------------

// File: rtl/fifo_drain.sv
// Read-side engine for the upstream fifo: pops words, absorbs the one-cycle read
// latency in a 2-entry skid buffer and streams them out as valid/ready with frame markers.
module fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_valid,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic              head_reg;
  logic [1:0]        buf_cnt_reg, buf_cnt_next;
  logic              inflight_reg;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic              err_reg;
  logic [1:0]        occ;
  logic              fire;
  logic              wr_en;
  logic              tail;
  logic [DATA_WIDTH-1:0] entry_data [2];

  assign occ     = buf_cnt_reg + {1'b0, inflight_reg};
  assign o_valid = (buf_cnt_reg != 2'd0);
  assign fire    = o_valid && i_ready;

  // A pop may only be issued when the word it returns is guaranteed a slot.
  assign o_fifo_pop = !rst && i_en && !i_fifo_empty &&
                      ((occ < 2'd2) || ((occ == 2'd2) && fire));

  // A word arriving on a full buffer can only be spurious; it is dropped.
  assign wr_en = i_fifo_valid && (buf_cnt_reg < 2'd2);
  assign tail  = head_reg ^ buf_cnt_reg[0];

  assign o_data = entry_data[head_reg];
  assign o_last = o_valid && (beat_reg == LAST_BEAT);
  assign o_busy = (occ != 2'd0);
  assign o_err  = err_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en && (tail == 1'(gi))) begin
          entry_reg <= i_fifo_data;
        end
      end

      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    buf_cnt_next = buf_cnt_reg;
    if (wr_en && !fire) begin
      buf_cnt_next = buf_cnt_reg + 2'd1;
    end else if (!wr_en && fire) begin
      buf_cnt_next = buf_cnt_reg - 2'd1;
    end
  end

  always_comb begin
    beat_next = beat_reg;
    if (fire) begin
      beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= 1'b0;
      buf_cnt_reg  <= 2'd0;
      inflight_reg <= 1'b0;
      beat_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      head_reg     <= head_reg ^ fire;
      buf_cnt_reg  <= buf_cnt_next;
      inflight_reg <= o_fifo_pop;
      beat_reg     <= beat_next;
      if (i_fifo_valid && !inflight_reg) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule
